param_ram: RTL and testbench
============================

# param_ram

Parametrised single-port synchronous RAM with byte-write enables, a request/ready handshake, an optional output pipeline register and a hardware initialisation sweep. After reset, and on request, every word is cleared to a known value, so software and later blocks never read uninitialised storage. It is the general-purpose storage primitive for the microcontroller datapath: register files, scratch memory and buffers instantiate it instead of fixed 16x8 or 64x8 arrays.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 4: address width; DEPTH = 2^ADDR_W words.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register for read latency 2.
- INIT_VAL, 0: DATA_W-bit value written to every word during initialisation.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  1  access request; sampled only while READY=1.
- WR  in  1  1 = write, 0 = read; qualifies REQ.
- ADDRESS  in  ADDR_W  word address.
- BE  in  DATA_W/8  byte enables for writes; bit i covers DATA_IN[8i+7:8i]. Ignored on reads.
- DATA_IN  in  DATA_W  write data.
- CLR  in  1  synchronous request to re-run the initialisation sweep.
- READY  out  1  block accepts requests; 0 during initialisation.
- DATA_OUT  out  DATA_W  read data; registered; holds its value until the next read completes.
- VALID  out  1  one-cycle pulse when DATA_OUT carries new read data.

## Operation
- FSM states: INIT, RUN.
- Reset (RST_N=0): state=INIT, init counter=0, READY=0, VALID=0, DATA_OUT=0, read pipeline flushed. Memory contents are not reset directly; the sweep clears them.
- INIT: each edge writes INIT_VAL to ram[counter] with all bytes enabled, then increments the counter. When the edge writes word DEPTH-1, the FSM moves to RUN and READY=1 from that edge onward. REQ and CLR are ignored in INIT.
- RUN: a request is accepted on an edge where REQ=1, READY=1 and CLR=0.
  - Accepted write: each byte i with BE[i]=1 is updated from DATA_IN; bytes with BE[i]=0 keep their value. BE=0 is a legal no-op. A write never asserts VALID.
  - Accepted read: captures ram[ADDRESS] and completes per Timing. Back-to-back reads are allowed, one per cycle.
- CLR=1 in RUN: at that edge, state goes to INIT, counter goes to 0 and READY goes to 0. CLR takes precedence over a REQ in the same cycle, so that REQ is dropped. Reads already in the pipeline still complete with their captured data.
- Read-after-write to the same address on the next cycle returns the new data. Read and write cannot coincide on this single port.
- Address range is the full 2^ADDR_W, so there is no out-of-range case. The init counter stops at DEPTH-1 and does not wrap.

## Timing
- Initialisation: after RST_N deasserts, DEPTH rising edges are needed. READY is high after edge DEPTH; the first request can be accepted at edge DEPTH+1.
- The same DEPTH-edge sweep applies after CLR.
- Read latency with OUT_REG=0: request accepted at edge N; DATA_OUT updated and VALID=1 after edge N+1 for one cycle.
- Read latency with OUT_REG=1: DATA_OUT and VALID appear after edge N+2.
- Write latency: the memory is updated at the accepting edge N. A read accepted at edge N+1 returns the written data.
- Throughput: 1 access per cycle in RUN. READY depends only on FSM state, never on REQ.
- RST_N asserted mid-read: VALID drops immediately, DATA_OUT=0, and no stale VALID pulse occurs after reset releases.

## Test plan
- Reset release, DEPTH=16, INIT_VAL=8'hA5 -> READY rises after exactly 16 edges; reading all 16 addresses returns 8'hA5 with one VALID per read.
- DATA_W=32: write 32'h11223344 to addr 3, then write 32'hFFFFFFFF to addr 3 with BE=4'b0101 -> reading addr 3 returns 32'h11FF33FF.
- Back-to-back reads of addr 0..3 after writes 1..4, run with OUT_REG=0 and then OUT_REG=1 -> data 1,2,3,4 on consecutive cycles at latency 1 and 2 respectively; VALID is high for exactly 4 cycles.
- CLR and a write REQ asserted together with 2 reads in flight (OUT_REG=1) -> both reads deliver their data; the write is dropped; READY stays low for 16 cycles; all words then read INIT_VAL.
- RST_N pulsed low for 1 ns between the accepting edge of a read and its output edge -> VALID never pulses, DATA_OUT=0, and the init sweep restarts from address 0.
- Write addr 5 = 8'h3C at edge N, then read addr 5 at edge N+1 -> DATA_OUT=8'h3C at latency 1; a write with BE=0 to addr 5 leaves it at 8'h3C.

Source files
------------

// File: rtl/param_ram.sv
// param_ram: single-port synchronous RAM with byte enables and a
// hardware init sweep. Its read path has an optional output register.
`timescale 1ns/1ps
module param_ram #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 OUT_REG  = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REQ,
  input  logic                WR,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [DATA_W-1:0]   DATA_IN,
  input  logic                CLR,
  output logic                READY,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic                VALID
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_v_q;
  logic [DATA_W-1:0]   rd_d_q;
  logic                last_v;
  logic [DATA_W-1:0]   last_d;
  logic                valid_q;
  logic [DATA_W-1:0]   dout_q;

  logic accept;
  logic wr_acc;
  logic rd_acc;

  assign accept = REQ & ready_q & ~CLR;
  assign wr_acc = accept & WR;
  assign rd_acc = accept & ~WR;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (&cnt_q) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (CLR) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage has no reset; the sweep is what gives it a known value.
  always_ff @(posedge CLK) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (BE[b]) mem[ADDRESS][8*b +: 8] <= DATA_IN[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_v_q <= 1'b0;
      rd_d_q <= '0;
    end else begin
      rd_v_q <= rd_acc;
      if (rd_acc) rd_d_q <= mem[ADDRESS];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              p_v_q;
    logic [DATA_W-1:0] p_d_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        p_v_q <= 1'b0;
        p_d_q <= '0;
      end else begin
        p_v_q <= rd_v_q;
        if (rd_v_q) p_d_q <= rd_d_q;
      end
    end

    assign last_v = p_v_q;
    assign last_d = p_d_q;
  end else begin : g_noreg
    assign last_v = rd_v_q;
    assign last_d = rd_d_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= last_v;
      if (last_v) dout_q <= last_d;
    end
  end

  assign READY    = ready_q;
  assign VALID    = valid_q;
  assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: drives a latency-1 and a latency-2 param_ram in lockstep
// and checks both against an array model of the memory.
`timescale 1ns/1ps
module tb_param_ram;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] din = '0;
  logic        clr = 1'b0;
  logic        ready0, ready1, valid0, valid1;
  logic [31:0] dout0, dout1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mdl [16];
  bit          mready = 1'b0;
  logic [31:0] eq_d[$];
  int          eq_c[$];
  logic [31:0] q0d[$], q1d[$];
  int          q0c[$], q1c[$];

  always #5 clk = ~clk;

  param_ram #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0), .INIT_VAL(IV)) u0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .WR(wr), .ADDRESS(addr),
    .BE(be), .DATA_IN(din), .CLR(clr), .READY(ready0),
    .DATA_OUT(dout0), .VALID(valid0));

  param_ram #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .INIT_VAL(IV)) u1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .WR(wr), .ADDRESS(addr),
    .BE(be), .DATA_IN(din), .CLR(clr), .READY(ready1),
    .DATA_OUT(dout1), .VALID(valid1));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid0) begin q0d.push_back(dout0); q0c.push_back(cyc); end
    if (valid1) begin q1d.push_back(dout1); q1c.push_back(cyc); end
  end

  task automatic clear_all();
    q0d.delete(); q0c.delete(); q1d.delete(); q1c.delete();
    eq_d.delete(); eq_c.delete();
  endtask

  task automatic fill_model();
    for (int i = 0; i < 16; i++) mdl[i] = IV;
  endtask

  // One request slot; the model decides acceptance from its own ready view.
  task automatic op(input logic r, input logic w, input logic [3:0] a,
                    input logic [3:0] b, input logic [31:0] d,
                    input logic c);
    @(negedge clk);
    req = r; wr = w; addr = a; be = b; din = d; clr = c;
    if (mready && c) begin
      mready = 1'b0;
      fill_model();
    end else if (mready && r && w) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
    end else if (mready && r) begin
      eq_d.push_back(mdl[a]);
      eq_c.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(ready0 && ready1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    mready = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    #3;
    checks++;
    if (ready0 !== 1'b0 || valid0 !== 1'b0 || dout0 !== 32'h0 ||
        ready1 !== 1'b0 || valid1 !== 1'b0 || dout1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state rdy=%b%b vld=%b%b d0=%h d1=%h want 0",
               ready0, ready1, valid0, valid1, dout0, dout1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fill_model();
    wait_ready(n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL reset_sweep_edges got=%0d want=16", n);
    end
  endtask

  task automatic test_init_read();
    clear_all();
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 4'(i), 4'h0, 32'h0, 1'b0);
    idle(4);
    checks++;
    if (q0d.size() != 16 || q1d.size() != 16) begin
      failures++;
      $display("FAIL init_valid_count got=%0d/%0d want=16", q0d.size(), q1d.size());
    end
    for (int i = 0; i < 16 && i < q0d.size() && i < q1d.size(); i++) begin
      checks++;
      if (q0d[i] !== IV || q1d[i] !== IV ||
          q0c[i] !== eq_c[i] + 1 || q1c[i] !== eq_c[i] + 2) begin
        failures++;
        $display("FAIL init_read[%0d] got=%h/%h @%0d/%0d want=%h @%0d/%0d",
                 i, q0d[i], q1d[i], q0c[i], q1c[i], IV, eq_c[i]+1, eq_c[i]+2);
      end
    end
  endtask

  task automatic test_byte_en();
    clear_all();
    op(1'b1, 1'b1, 4'd3, 4'hF, 32'h11223344, 1'b0);
    op(1'b1, 1'b1, 4'd3, 4'b0101, 32'hFFFFFFFF, 1'b0);
    op(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b0);
    idle(4);
    checks++;
    if (q0d.size() != 1 || q1d.size() != 1) begin
      failures++;
      $display("FAIL byte_en_count got=%0d/%0d want=1", q0d.size(), q1d.size());
    end else if (q0d[0] !== 32'h11FF33FF || q1d[0] !== 32'h11FF33FF) begin
      failures++;
      $display("FAIL byte_en_data got=%h/%h want=11ff33ff", q0d[0], q1d[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    for (int i = 0; i < 4; i++) op(1'b1, 1'b1, 4'(i), 4'hF, 32'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 4'(i), 4'h0, 32'h0, 1'b0);
    idle(4);
    checks++;
    if (q0d.size() != 4 || q1d.size() != 4) begin
      failures++;
      $display("FAIL b2b_valid_cycles got=%0d/%0d want=4", q0d.size(), q1d.size());
    end
    for (int i = 0; i < 4 && i < q0d.size() && i < q1d.size(); i++) begin
      checks++;
      if (q0d[i] !== 32'(i + 1) || q1d[i] !== 32'(i + 1) ||
          q0c[i] !== eq_c[0] + 1 + i || q1c[i] !== eq_c[0] + 2 + i) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h/%h @%0d/%0d want=%h @%0d/%0d",
                 i, q0d[i], q1d[i], q0c[i], q1c[i], i + 1,
                 eq_c[0] + 1 + i, eq_c[0] + 2 + i);
      end
    end
  endtask

  task automatic test_raw();
    clear_all();
    op(1'b1, 1'b1, 4'd5, 4'hF, 32'h0000003C, 1'b0);
    op(1'b1, 1'b0, 4'd5, 4'h0, 32'h0, 1'b0);
    op(1'b1, 1'b1, 4'd5, 4'h0, 32'hDEADBEEF, 1'b0);
    op(1'b1, 1'b0, 4'd5, 4'h0, 32'h0, 1'b0);
    idle(4);
    checks++;
    if (q0d.size() != 2 || q1d.size() != 2) begin
      failures++;
      $display("FAIL raw_count got=%0d/%0d want=2", q0d.size(), q1d.size());
    end else begin
      checks++;
      if (q0d[0] !== 32'h3C || q0c[0] !== eq_c[0] + 1 || q1d[0] !== 32'h3C) begin
        failures++;
        $display("FAIL raw_read got=%h/%h @%0d want=0000003c @%0d",
                 q0d[0], q1d[0], q0c[0], eq_c[0] + 1);
      end
      checks++;
      if (q0d[1] !== 32'h3C || q1d[1] !== 32'h3C) begin
        failures++;
        $display("FAIL raw_be0 got=%h/%h want=0000003c", q0d[1], q1d[1]);
      end
    end
  endtask

  task automatic test_clr();
    int n;
    clear_all();
    op(1'b1, 1'b1, 4'd9, 4'hF, 32'h12345678, 1'b0);
    op(1'b1, 1'b0, 4'd9, 4'h0, 32'h0, 1'b0);
    op(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b0);
    op(1'b1, 1'b1, 4'd2, 4'hF, 32'hCAFEF00D, 1'b1);
    @(negedge clk);
    req = 1'b0; clr = 1'b0;
    checks++;
    if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
      failures++;
      $display("FAIL clr_ready_drop got=%b%b want=00", ready0, ready1);
    end
    wait_ready(n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL clr_sweep_edges got=%0d want=16", n);
    end
    checks++;
    if (q0d.size() != 2 || q1d.size() != 2) begin
      failures++;
      $display("FAIL clr_inflight_count got=%0d/%0d want=2", q0d.size(), q1d.size());
    end else if (q0d[0] !== eq_d[0] || q0d[1] !== eq_d[1] ||
                 q1d[0] !== eq_d[0] || q1d[1] !== eq_d[1]) begin
      failures++;
      $display("FAIL clr_inflight_data got=%h,%h/%h,%h want=%h,%h",
               q0d[0], q0d[1], q1d[0], q1d[1], eq_d[0], eq_d[1]);
    end
    clear_all();
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 4'(i), 4'h0, 32'h0, 1'b0);
    idle(4);
    checks++;
    if (q0d.size() != 16 || q1d.size() != 16) begin
      failures++;
      $display("FAIL clr_readback_count got=%0d/%0d want=16", q0d.size(), q1d.size());
    end
    for (int i = 0; i < 16 && i < q0d.size() && i < q1d.size(); i++) begin
      checks++;
      if (q0d[i] !== IV || q1d[i] !== IV) begin
        failures++;
        $display("FAIL clr_readback[%0d] got=%h/%h want=%h", i, q0d[i], q1d[i], IV);
      end
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int t = 0; t < 300; t++) begin
      op(($urandom % 4) != 0, $urandom % 2, 4'($urandom), 4'($urandom),
         $urandom, 1'b0);
    end
    idle(4);
    checks++;
    if (q0d.size() != eq_d.size() || q1d.size() != eq_d.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d/%0d want=%0d",
               q0d.size(), q1d.size(), eq_d.size());
    end
    for (int i = 0; i < eq_d.size() && i < q0d.size() && i < q1d.size(); i++) begin
      checks++;
      if (q0d[i] !== eq_d[i] || q1d[i] !== eq_d[i] ||
          q0c[i] !== eq_c[i] + 1 || q1c[i] !== eq_c[i] + 2) begin
        failures++;
        $display("FAIL rand[%0d] got=%h/%h @%0d/%0d want=%h @%0d/%0d",
                 i, q0d[i], q1d[i], q0c[i], q1c[i], eq_d[i], eq_c[i]+1, eq_c[i]+2);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    clear_all();
    op(1'b1, 1'b0, 4'd7, 4'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    mready = 1'b0;
    fill_model();
    #0.5;
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0 || dout0 !== 32'h0 ||
        dout1 !== 32'h0 || ready0 !== 1'b0 || ready1 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs vld=%b%b d=%h/%h rdy=%b%b want 0",
               valid0, valid1, dout0, dout1, ready0, ready1);
    end
    #0.5 rst_n = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL midrst_sweep_edges got=%0d want=16", n);
    end
    checks++;
    if (q0d.size() != 0 || q1d.size() != 0) begin
      failures++;
      $display("FAIL midrst_stale_valid got=%0d/%0d want=0", q0d.size(), q1d.size());
    end
    clear_all();
    op(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0);
    op(1'b1, 1'b0, 4'd15, 4'h0, 32'h0, 1'b0);
    idle(4);
    checks++;
    if (q0d.size() != 2 || q1d.size() != 2) begin
      failures++;
      $display("FAIL midrst_readback_count got=%0d/%0d want=2", q0d.size(), q1d.size());
    end else if (q0d[0] !== IV || q0d[1] !== IV || q1d[0] !== IV || q1d[1] !== IV) begin
      failures++;
      $display("FAIL midrst_readback got=%h,%h/%h,%h want=%h",
               q0d[0], q0d[1], q1d[0], q1d[1], IV);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_read();
    test_byte_en();
    test_back_to_back();
    test_raw();
    test_clr();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
